fifo_sync_param: RTL

//   Parametrised single-clock FIFO: generic data width and power-of-two depth, standard or

---
 rtl/fifo_sync_param.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO over a register array. The read port is either registered
// (one cycle after read) or first-word-fall-through, chosen by the FWFT parameter.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] buff_in,
  input  logic                  read,
  input  logic                  err_clr,
  input  logic [ADDR_WIDTH:0]   umb_almost_full,
  input  logic [ADDR_WIDTH:0]   umb_almost_empty,
  output logic [DATA_WIDTH-1:0] buff_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_rd_ok = read & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_wr_ok = write & (~w_full | w_rd_ok);

  always_ff @(posedge clk) begin
    if (reset_L) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A fresh rejection in the same cycle beats the clear.
      if (write & ~w_wr_ok)     r_overflow <= 1'b1;
      else if (err_clr)         r_overflow <= 1'b0;
      if (read & ~w_rd_ok)      r_underflow <= 1'b1;
      else if (err_clr)         r_underflow <= 1'b0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset_L && w_wr_ok) r_mem[r_wr_ptr] <= buff_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign buff_out  = w_empty ? '0 : r_mem[r_rd_ptr];
      assign valid_out = ~w_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_buff_out;
      logic                  r_valid_out;

      always_ff @(posedge clk) begin
        if (reset_L) begin
          r_buff_out  <= '0;
          r_valid_out <= 1'b0;
        end else if (w_rd_ok) begin
          r_buff_out  <= r_mem[r_rd_ptr];
          r_valid_out <= 1'b1;
        end else begin
          r_valid_out <= 1'b0;
        end
      end

      assign buff_out  = r_buff_out;
      assign valid_out = r_valid_out;
    end
  endgenerate

  assign data_count   = r_count;
  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign almost_full  = (umb_almost_full != '0) && (r_count >= umb_almost_full);
  assign almost_empty = (r_count <= umb_almost_empty);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
